// File: rtl/sap_control_sequencer_pkg.sv
// Shared definitions for the SAP control sequencer: opcodes,
// control-word bit map, FSM states and the microcode decode.
package sap_pkg;

  localparam int CW_W = 16;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam int B_HLT = 15;
  localparam int B_MI  = 14;
  localparam int B_RI  = 13;
  localparam int B_RO  = 12;
  localparam int B_IO  = 11;
  localparam int B_II  = 10;
  localparam int B_AI  = 9;
  localparam int B_AO  = 8;
  localparam int B_EO  = 7;
  localparam int B_SU  = 6;
  localparam int B_BI  = 5;
  localparam int B_OI  = 4;
  localparam int B_CE  = 3;
  localparam int B_CO  = 2;
  localparam int B_J   = 1;
  localparam int B_FI  = 0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_e;

  function automatic logic [CW_W-1:0] ctrl_decode(
    input logic [2:0] t,
    input logic [3:0] op,
    input logic       c,
    input logic       z
  );
    logic [CW_W-1:0] w;
    w = '0;
    case (t)
      3'd0: begin
        w[B_CO] = 1'b1;
        w[B_MI] = 1'b1;
      end
      3'd1: begin
        w[B_RO] = 1'b1;
        w[B_II] = 1'b1;
        w[B_CE] = 1'b1;
      end
      3'd2: begin
        case (op)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            w[B_IO] = 1'b1;
            w[B_MI] = 1'b1;
          end
          OP_LDI: begin
            w[B_IO] = 1'b1;
            w[B_AI] = 1'b1;
          end
          OP_JMP: begin
            w[B_IO] = 1'b1;
            w[B_J]  = 1'b1;
          end
          OP_JC: begin
            w[B_IO] = c;
            w[B_J]  = c;
          end
          OP_JZ: begin
            w[B_IO] = z;
            w[B_J]  = z;
          end
          OP_OUT: begin
            w[B_AO] = 1'b1;
            w[B_OI] = 1'b1;
          end
          OP_HLT: w[B_HLT] = 1'b1;
          default: w = '0;
        endcase
      end
      3'd3: begin
        case (op)
          OP_LDA: begin
            w[B_RO] = 1'b1;
            w[B_AI] = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            w[B_RO] = 1'b1;
            w[B_BI] = 1'b1;
          end
          OP_STA: begin
            w[B_AO] = 1'b1;
            w[B_RI] = 1'b1;
          end
          default: w = '0;
        endcase
      end
      3'd4: begin
        if (op == OP_ADD || op == OP_SUB) begin
          w[B_EO] = 1'b1;
          w[B_AI] = 1'b1;
          w[B_FI] = 1'b1;
          w[B_SU] = (op == OP_SUB);
        end
      end
      default: w = '0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/sap_control_sequencer_if.sv
// Sequencer <-> datapath bus. The step input only exists
// when SEQ_SINGLE_STEP_EN is defined.
interface sap_control_sequencer_if;
  import sap_pkg::*;

  logic            start;
  logic [3:0]      instr_opcode;
  logic            flag_carry;
  logic            flag_zero;
`ifdef SEQ_SINGLE_STEP_EN
  logic            step;
`endif
  logic [CW_W-1:0] ctrl_word;
  logic [2:0]      tstate;
  logic            running;
  logic            halted;

  modport master (
    input  start,
    input  instr_opcode,
    input  flag_carry,
    input  flag_zero,
`ifdef SEQ_SINGLE_STEP_EN
    input  step,
`endif
    output ctrl_word,
    output tstate,
    output running,
    output halted
  );

  modport slave (
    output start,
    output instr_opcode,
    output flag_carry,
    output flag_zero,
`ifdef SEQ_SINGLE_STEP_EN
    output step,
`endif
    input  ctrl_word,
    input  tstate,
    input  running,
    input  halted
  );

endinterface

// File: rtl/sap_control_sequencer_tstate_counter.sv
// Mod-5 T-state counter with enable and synchronous clear.
module tstate_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       clr,
  output logic [2:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= 3'd0;
    end else if (clr) begin
      q <= 3'd0;
    end else if (en) begin
      q <= (q == 3'd4) ? 3'd0 : q + 3'd1;
    end
  end

endmodule

// File: rtl/sap_control_sequencer.sv
// SAP microcoded control sequencer (IDLE/RUN/HALT, 5 T-states).
// Optional single-step mode: define SEQ_SINGLE_STEP_EN.
module sap_control_sequencer
  import sap_pkg::*;
(
  input logic                     clk,
  input logic                     reset,
  sap_control_sequencer_if.master bus
);

  state_e          state;
  state_e          state_nxt;
  logic            adv;
  logic            cnt_en;
  logic            cnt_clr;
  logic [2:0]      t;
  logic [CW_W-1:0] word;

`ifdef SEQ_SINGLE_STEP_EN
  assign adv = bus.step;
`else
  assign adv = 1'b1;
`endif

  tstate_counter u_tcnt (
    .clk   (clk),
    .reset (reset),
    .en    (cnt_en),
    .clr   (cnt_clr),
    .q     (t)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_en    = 1'b0;
    cnt_clr   = 1'b0;
    word      = '0;
    case (state)
      S_IDLE: begin
        cnt_clr = 1'b1;
        if (bus.start) begin
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        cnt_en = adv;
        word   = ctrl_decode(t, bus.instr_opcode,
                             bus.flag_carry, bus.flag_zero);
        if (adv && t == 3'd2 && bus.instr_opcode == OP_HLT) begin
          state_nxt = S_HALT;
          cnt_clr   = 1'b1;
        end
      end
      S_HALT: cnt_clr = 1'b1;
      default: begin
        state_nxt = S_IDLE;
        cnt_clr   = 1'b1;
      end
    endcase
  end

  // Gating by adv makes each latch/CE fire once per step pulse.
  assign bus.ctrl_word = word & {CW_W{adv}};
  assign bus.tstate    = (state == S_RUN) ? t : 3'd0;
  assign bus.running   = (state == S_RUN);
  assign bus.halted    = (state == S_HALT);

endmodule

// File: tb/tb_sap_control_sequencer.sv
// Scoreboard bench for sap_control_sequencer: directed vectors push
// expected outputs; a negedge monitor pops and compares.
module tb_sap_control_sequencer;

  typedef struct {
    string       nm;
    logic [15:0] cw;
    logic [2:0]  t;
    logic        r;
    logic        h;
  } exp_t;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_bad;
  exp_t sb[$];

  sap_control_sequencer_if bus ();

  sap_control_sequencer dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input exp_t e);
    n_vec++;
    if (bus.ctrl_word !== e.cw || bus.tstate !== e.t ||
        bus.running !== e.r || bus.halted !== e.h) begin
      n_bad++;
      $display("FAIL %s: got cw=%h t=%0d run=%b halt=%b, want cw=%h t=%0d run=%b halt=%b",
               e.nm, bus.ctrl_word, bus.tstate, bus.running, bus.halted,
               e.cw, e.t, e.r, e.h);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      chk(sb.pop_front());
    end
  end

  task automatic v(
    input string       nm,
    input logic        rs,
    input logic        st,
    input logic [3:0]  op,
    input logic        c,
    input logic        z,
    input logic        stp,
    input logic [15:0] cw,
    input logic [2:0]  t,
    input logic        r,
    input logic        h
  );
    exp_t e;
    @(posedge clk);
    #1;
    rst              = rs;
    bus.start        = st;
    bus.instr_opcode = op;
    bus.flag_carry   = c;
    bus.flag_zero    = z;
`ifdef SEQ_SINGLE_STEP_EN
    bus.step         = stp;
`endif
    e.nm = nm;
    e.cw = cw;
    e.t  = t;
    e.r  = r;
    e.h  = h;
    sb.push_back(e);
  endtask

  task automatic fetch(input logic [3:0] op, input logic c,
                       input logic z);
    v("t0", 0, 0, op, c, z, 1, 16'h4004, 3'd0, 1, 0);
    v("t1", 0, 0, op, c, z, 1, 16'h1408, 3'd1, 1, 0);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t ea;
    logic [15:0] lda_w [5];
    n_vec = 0;
    n_bad = 0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.instr_opcode = 4'h0;
    bus.flag_carry = 1'b0;
    bus.flag_zero = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
    bus.step = 1'b1;
`endif
    v("rst", 1, 0, 4'h0, 0, 0, 1, 16'h0, 3'd0, 0, 0);
    for (int i = 0; i < 10; i++)
      v("idle", 0, 0, 4'h0, 0, 0, 1, 16'h0, 3'd0, 0, 0);
    v("start", 0, 1, 4'h1, 0, 0, 1, 16'h0, 3'd0, 0, 0);

    fetch(4'h1, 0, 0);
    v("lda_t2", 0, 0, 4'h1, 0, 0, 1, 16'h4800, 3'd2, 1, 0);
    v("lda_t3", 0, 0, 4'h1, 0, 0, 1, 16'h1200, 3'd3, 1, 0);
    v("lda_t4", 0, 0, 4'h1, 0, 0, 1, 16'h0000, 3'd4, 1, 0);

    fetch(4'h7, 1, 0);
    v("jc1_t2", 0, 0, 4'h7, 1, 0, 1, 16'h0802, 3'd2, 1, 0);
    v("jc1_t3", 0, 0, 4'h7, 1, 0, 1, 16'h0000, 3'd3, 1, 0);
    v("jc1_t4", 0, 0, 4'h7, 1, 0, 1, 16'h0000, 3'd4, 1, 0);
    fetch(4'h7, 0, 1);
    v("jc0_t2", 0, 0, 4'h7, 0, 1, 1, 16'h0000, 3'd2, 1, 0);
    v("jc0_t3", 0, 0, 4'h7, 0, 1, 1, 16'h0000, 3'd3, 1, 0);
    v("jc0_t4", 0, 0, 4'h7, 0, 1, 1, 16'h0000, 3'd4, 1, 0);
    fetch(4'h8, 1, 1);
    v("jz1_t2", 0, 0, 4'h8, 1, 1, 1, 16'h0802, 3'd2, 1, 0);
    v("jz1_t3", 0, 0, 4'h8, 1, 1, 1, 16'h0000, 3'd3, 1, 0);
    v("jz1_t4", 0, 0, 4'h8, 1, 1, 1, 16'h0000, 3'd4, 1, 0);

    fetch(4'h2, 0, 0);
    v("add_t2", 0, 0, 4'h2, 0, 0, 1, 16'h4800, 3'd2, 1, 0);
    v("add_t3", 0, 0, 4'h2, 0, 0, 1, 16'h1020, 3'd3, 1, 0);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    ea.nm = "async_rst";
    ea.cw = 16'h0;
    ea.t = 3'd0;
    ea.r = 1'b0;
    ea.h = 1'b0;
    chk(ea);
    v("rst_hold", 1, 0, 4'h2, 0, 0, 1, 16'h0, 3'd0, 0, 0);
    v("restart", 0, 1, 4'h4, 0, 0, 1, 16'h0, 3'd0, 0, 0);

    fetch(4'h4, 0, 0);
    v("sta_t2", 0, 0, 4'h4, 0, 0, 1, 16'h4800, 3'd2, 1, 0);
    v("sta_t3", 0, 0, 4'h4, 0, 0, 1, 16'h2100, 3'd3, 1, 0);
    v("sta_t4", 0, 0, 4'h4, 0, 0, 1, 16'h0000, 3'd4, 1, 0);
    fetch(4'h5, 0, 0);
    v("ldi_t2", 0, 0, 4'h5, 0, 0, 1, 16'h0A00, 3'd2, 1, 0);
    v("ldi_t3", 0, 0, 4'h5, 0, 0, 1, 16'h0000, 3'd3, 1, 0);
    v("ldi_t4", 0, 0, 4'h5, 0, 0, 1, 16'h0000, 3'd4, 1, 0);
    fetch(4'hE, 0, 0);
    v("out_t2", 0, 0, 4'hE, 0, 0, 1, 16'h0110, 3'd2, 1, 0);
    v("out_t3", 0, 0, 4'hE, 0, 0, 1, 16'h0000, 3'd3, 1, 0);
    v("out_t4", 0, 0, 4'hE, 0, 0, 1, 16'h0000, 3'd4, 1, 0);
    fetch(4'h3, 0, 0);
    v("sub_t2", 0, 0, 4'h3, 0, 0, 1, 16'h4800, 3'd2, 1, 0);
    v("sub_t3", 0, 0, 4'h3, 0, 0, 1, 16'h1020, 3'd3, 1, 0);
    v("sub_t4", 0, 0, 4'h3, 0, 0, 1, 16'h02C1, 3'd4, 1, 0);
    fetch(4'hA, 0, 0);
    v("nop_t2", 0, 0, 4'hA, 0, 0, 1, 16'h0000, 3'd2, 1, 0);
    v("nop_t3", 0, 0, 4'hA, 0, 0, 1, 16'h0000, 3'd3, 1, 0);
    v("nop_t4", 0, 0, 4'hA, 0, 0, 1, 16'h0000, 3'd4, 1, 0);
    fetch(4'h6, 0, 0);
    v("jmp_t2", 0, 0, 4'h6, 0, 0, 1, 16'h0802, 3'd2, 1, 0);
    v("jmp_t3", 0, 0, 4'h6, 0, 0, 1, 16'h0000, 3'd3, 1, 0);
    v("jmp_t4", 0, 0, 4'h6, 0, 0, 1, 16'h0000, 3'd4, 1, 0);
    fetch(4'hF, 0, 0);
    v("hlt_t2", 0, 0, 4'hF, 0, 0, 1, 16'h8000, 3'd2, 1, 0);
    for (int i = 0; i < 20; i++)
      v("halt", 0, (i == 5), 4'hF, 0, 0, 1, 16'h0, 3'd0, 0, 1);
    v("rst_halt", 1, 0, 4'h0, 0, 0, 1, 16'h0, 3'd0, 0, 0);
    v("post_rst", 0, 0, 4'h0, 0, 0, 1, 16'h0, 3'd0, 0, 0);

`ifdef SEQ_SINGLE_STEP_EN
    lda_w[0] = 16'h4004;
    lda_w[1] = 16'h1408;
    lda_w[2] = 16'h4800;
    lda_w[3] = 16'h1200;
    lda_w[4] = 16'h0000;
    v("ss_start", 0, 1, 4'h1, 0, 0, 0, 16'h0, 3'd0, 0, 0);
    for (int ts = 0; ts < 5; ts++) begin
      for (int k = 0; k < 3; k++)
        v("ss_wait", 0, 0, 4'h1, 0, 0, 0, 16'h0, 3'(ts), 1, 0);
      v("ss_step", 0, 0, 4'h1, 0, 0, 1, lda_w[ts], 3'(ts), 1, 0);
    end
    v("ss_wrap", 0, 0, 4'h1, 0, 0, 0, 16'h0, 3'd0, 1, 0);
`else
    lda_w[0] = 16'h0;
    lda_w[1] = 16'h0;
    lda_w[2] = 16'h0;
    lda_w[3] = 16'h0;
    lda_w[4] = 16'h0;
`endif

    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
